// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants and the width helper used for pointer/count sizing.
package uart_rx_fifo_pkg;
  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rx_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH registers, one synchronous write port, one asynchronous read port.
module rx_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  sys_clk,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_dat_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_addr_i];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: one write per rising edge of rx_data_ready, FWFT pop port; almost_full via UART_RX_FIFO_AFULL_EN.
// Latency: byte pushed at edge T is at rd_data in cycle T+1. Backpressure: none toward receiver; drops when full set sticky overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int DEPTH       = UART_FIFO_DEPTH,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      rx_data_in,
  input  logic                       rx_data_ready,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [clog2(DEPTH):0]      count,
  output logic                       full,
  output logic                       overrun,
  input  logic                       overrun_clr
`ifdef UART_RX_FIFO_AFULL_EN
  ,
  output logic                       almost_full
`endif
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH - 1) begin : g_bad_afull
    $error("uart_rx_fifo: AFULL_LEVEL must be in 1..DEPTH-1");
  end

  logic          rdy_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, full_q, overrun_q, overrun_d;
  logic          push, pop, wr_en, drop;

  assign push  = rx_data_ready && !rdy_q;
  assign pop   = rd_valid_q && rd_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full_q || pop);
  assign drop  = push && full_q && !pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
  end

  assign overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rdy_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rdy_q      <= rx_data_ready;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      rd_valid_q <= (count_d != '0);
      full_q     <= (count_d == CW'(DEPTH));
      overrun_q  <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_AFULL_EN
  logic afull_q;

  always_ff @(posedge sys_clk) begin
    if (reset) afull_q <= 1'b0;
    else       afull_q <= (count_d >= CW'(AFULL_LEVEL));
  end

  assign almost_full = afull_q;
`endif

  rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .sys_clk   (sys_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_dat_i  (rx_data_in),
    .rd_addr_i (rd_ptr_q),
    .rd_dat_o  (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = full_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based reference model checked every cycle.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data_in;
  logic       rx_data_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic       overrun_clr;
`ifdef UART_RX_FIFO_AFULL_EN
  logic       almost_full;
`endif

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AFULL_LEVEL(12)) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .rx_data_in    (rx_data_in),
    .rx_data_ready (rx_data_ready),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .count         (count),
    .full          (full),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    .almost_full   (almost_full)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the previous receiver flag and the sticky overrun bit.
  logic [7:0] mq[$];
  bit         m_prev = 1'b1;
  bit         m_ovr  = 1'b0;
  bit         model_on = 1'b0;

  always @(posedge sys_clk) begin
    bit m_push, m_pop, m_drop;
    if (reset) begin
      mq.delete();
      m_prev = 1'b1;
      m_ovr  = 1'b0;
    end else begin
      m_push = rx_data_ready && !m_prev;
      m_pop  = (mq.size() != 0) && rd_ready;
      if (m_pop) void'(mq.pop_front());
      m_drop = 1'b0;
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(rx_data_in);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      m_prev = rx_data_ready;
    end
  end

  always @(negedge sys_clk) begin
    if (model_on) begin
      chk("m_valid", rd_valid, mq.size() != 0);
      if (mq.size() != 0) chk("m_data", rd_data, mq[0]);
      chk("m_count", count, mq.size());
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_overrun", overrun, m_ovr);
`ifdef UART_RX_FIFO_AFULL_EN
      chk("m_afull", almost_full, mq.size() >= 12);
`endif
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data_in    = b;
    rx_data_ready = 1'b1;
    tick();
    tick();
    rx_data_ready = 1'b0;
    tick();
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    rd_ready = 1'b1;
    @(negedge sys_clk);
    chk(name, rd_data, exp);
    chk({name, "_vld"}, rd_valid, 1'b1);
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_data_in = '0; rx_data_ready = 1'b0; rd_ready = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    @(negedge sys_clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);
    model_on = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Single byte: flag held for 20 cycles yields exactly one entry.
    rx_data_in = 8'hA5; rx_data_ready = 1'b1;
    tick();
    @(negedge sys_clk);
    chk("single_valid", rd_valid, 1);
    chk("single_data", rd_data, 8'hA5);
    chk("single_count", count, 1);
    for (int i = 0; i < 19; i++) tick();
    chk("single_hold_count", count, 1);
    rx_data_ready = 1'b0;
    tick();
    pop_expect("single_pop", 8'hA5);
    chk("single_empty", count, 0);

    // Fill to full, overflow with 0x10, drain in order.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    push_byte(8'h10);
    chk("ovf_overrun", overrun, 1);
    chk("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) pop_expect("drain", 8'(i));
    chk("drain_empty", rd_valid, 0);
    chk("drain_count", count, 0);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    rx_data_in = 8'h55; rx_data_ready = 1'b1; rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
    rx_data_ready = 1'b0;
    tick();
    chk("fullpp_count", count, 16);
    chk("fullpp_overrun", overrun, 0);
    for (int i = 1; i < 16; i++) pop_expect("fullpp_drain", 8'h20 + 8'(i));
    pop_expect("fullpp_last", 8'h55);

    // Pointer wrap at occupancy 3.
    for (int k = 0; k < 3; k++) push_byte(8'h80 + 8'(k));
    for (int k = 0; k < 40; k++) begin
      rx_data_in = 8'h80 + 8'(k + 3); rx_data_ready = 1'b1; rd_ready = 1'b1;
      @(negedge sys_clk);
      chk("wrap_data", rd_data, 8'h80 + 8'(k));
      chk("wrap_count", count, 3);
      tick();
      rx_data_ready = 1'b0; rd_ready = 1'b0;
      tick();
    end
    for (int k = 40; k < 43; k++) pop_expect("wrap_tail", 8'h80 + 8'(k));

    // Reset with data in flight and the flag high.
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    chk("hz_pre_count", count, 5);
    rx_data_in = 8'h99; rx_data_ready = 1'b1; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("hz_count", count, 0);
    chk("hz_valid", rd_valid, 0);
    rx_data_ready = 1'b0; tick();
    rx_data_ready = 1'b1; tick();
    chk("hz_repush_count", count, 1);
    chk("hz_repush_data", rd_data, 8'h99);
    rx_data_ready = 1'b0; tick();
    pop_expect("hz_pop", 8'h99);

    // Overrun clear colliding with a drop; almost_full threshold while filling.
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h40 + 8'(i));
`ifdef UART_RX_FIFO_AFULL_EN
      chk("afull_step", almost_full, i >= 11);
`endif
    end
    rx_data_in = 8'h77; rx_data_ready = 1'b1; overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("clr_vs_drop", overrun, 1);
    rx_data_ready = 1'b0;
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("clr_after", overrun, 0);
    for (int i = 0; i < 16; i++) pop_expect("final_drain", 8'h40 + 8'(i));
    chk("final_count", count, 0);
    tick();

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
